sprite_draw_sequencer: RTL

//  Per-frame draw scheduler for the Pong datapath, generalised to NUM_OBJ objects (paddles, ball, score digits).
//  On each frame_tick it walks every object's WxH raster, one pixel per accepted cycle, feeding the VGA plot datapath.

---
 rtl/sprite_draw_sequencer_pkg.sv | 16 +
 rtl/sprite_draw_sequencer_raster_walker.sv | 61 ++++++
 rtl/sprite_draw_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sprite_draw_sequencer_pkg.sv
// Shared types and constants for the sprite draw sequencer: FSM state encoding
// and the pass flag values carried on the erase output.
package sprite_draw_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_DRAW = 3'd2,
    ST_NEXT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic PASS_ERASE = 1'b1;
  localparam logic PASS_DRAW  = 1'b0;

endpackage

// File: rtl/sprite_draw_sequencer_raster_walker.sv
// Raster walker: steps dx across a row, then dy down the rows, of a WxH object.
// last_pixel flags the final (w-1, h-1) coordinate so the caller can leave DRAW.
module raster_walker #(
  parameter int W_BITS = 8,
  parameter int H_BITS = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [W_BITS-1:0] w,
  input  logic [H_BITS-1:0] h,
  output logic [W_BITS-1:0] dx,
  output logic [H_BITS-1:0] dy,
  output logic              last_pixel
);

  logic [W_BITS-1:0] dx_q, dx_d;
  logic [H_BITS-1:0] dy_q, dy_d;
  logic              row_end;
  logic              col_end;

  // w and h are nonzero whenever advance is asserted, so w-1/h-1 never wrap.
  assign row_end    = (dx_q == w - W_BITS'(1));
  assign col_end    = (dy_q == h - H_BITS'(1));
  assign last_pixel = row_end && col_end;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clear) begin
      dx_d = '0;
      dy_d = '0;
    end else if (advance) begin
      if (row_end) begin
        dx_d = '0;
        dy_d = col_end ? '0 : dy_q + 1'b1;
      end else begin
        dx_d = dx_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its _d input, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx = dx_q;
  assign dy = dy_q;

endmodule

// File: rtl/sprite_draw_sequencer.sv
// Per-frame draw scheduler: on frame_tick walks each object's raster (optionally
// an erase pass first), one pixel per accepted plot cycle, and flags overruns.
module sprite_draw_sequencer
  import sprite_draw_sequencer_pkg::*;
#(
  parameter int NUM_OBJ  = 3,
  parameter int IDX_BITS = 2,
  parameter int W_BITS   = 8,
  parameter int H_BITS   = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic                      erase_en,
  input  logic [NUM_OBJ*W_BITS-1:0] obj_w,
  input  logic [NUM_OBJ*H_BITS-1:0] obj_h,
  input  logic                      plot_ready,
  output logic                      plot,
  output logic                      erase,
  output logic [IDX_BITS-1:0]       obj_idx,
  output logic [W_BITS-1:0]         dx,
  output logic [H_BITS-1:0]         dy,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_OBJ - 1);

  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] obj_idx_q, obj_idx_d;
  logic                erase_q, erase_d;
  logic                overrun_q, overrun_d;
  logic [W_BITS-1:0]   w_q, w_d, sel_w;
  logic [H_BITS-1:0]   h_q, h_d, sel_h;
  logic                walk_clear;
  logic                walk_adv;
  logic                last_pixel;

  always_comb begin
    sel_w = '0;
    sel_h = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (obj_idx_q == IDX_BITS'(i)) begin
        sel_w = obj_w[i*W_BITS +: W_BITS];
        sel_h = obj_h[i*H_BITS +: H_BITS];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    obj_idx_d  = obj_idx_q;
    erase_d    = erase_q;
    w_d        = w_q;
    h_d        = h_q;
    walk_clear = 1'b0;
    walk_adv   = 1'b0;
    // A tick in any non-idle state, DONE included, is dropped but remembered.
    overrun_d  = overrun_q | (frame_tick && (state_q != ST_IDLE));
    unique case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d   = ST_LOAD;
          obj_idx_d = '0;
          erase_d   = erase_en;
        end
      end
      ST_LOAD: begin
        w_d        = sel_w;
        h_d        = sel_h;
        walk_clear = 1'b1;
        state_d    = (sel_w == '0 || sel_h == '0) ? ST_NEXT : ST_DRAW;
      end
      ST_DRAW: begin
        if (plot_ready) begin
          walk_adv = 1'b1;
          if (last_pixel) state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (obj_idx_q != LAST_IDX) begin
          obj_idx_d = obj_idx_q + 1'b1;
          state_d   = ST_LOAD;
        end else if (erase_q == PASS_ERASE) begin
          erase_d   = PASS_DRAW;
          obj_idx_d = '0;
          state_d   = ST_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      obj_idx_q <= '0;
      erase_q   <= PASS_DRAW;
      overrun_q <= 1'b0;
      w_q       <= '0;
      h_q       <= '0;
    end else begin
      state_q   <= state_d;
      obj_idx_q <= obj_idx_d;
      erase_q   <= erase_d;
      overrun_q <= overrun_d;
      w_q       <= w_d;
      h_q       <= h_d;
    end
  end

  raster_walker #(
    .W_BITS(W_BITS),
    .H_BITS(H_BITS)
  ) u_walker (
    .clk       (clk),
    .reset     (reset),
    .clear     (walk_clear),
    .advance   (walk_adv),
    .w         (w_q),
    .h         (h_q),
    .dx        (dx),
    .dy        (dy),
    .last_pixel(last_pixel)
  );

  assign plot       = (state_q == ST_DRAW);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign erase      = erase_q;
  assign obj_idx    = obj_idx_q;
  assign overrun    = overrun_q;

endmodule
